// File: rtl/ysyx_23060025_rd_arbiter.sv
// Two-master (IFU m0, LSU m1) to one-slave read-channel arbiter, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority m1 > m0.
module ysyx_23060025_rd_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] m0_ar_addr,
  input  logic                m0_ar_valid,
  output logic                m0_ar_ready,
  output logic [DATA_LEN-1:0] m0_r_data,
  output logic [1:0]          m0_r_resp,
  output logic                m0_r_valid,
  input  logic                m0_r_ready,
  input  logic [ADDR_LEN-1:0] m1_ar_addr,
  input  logic                m1_ar_valid,
  output logic                m1_ar_ready,
  output logic [DATA_LEN-1:0] m1_r_data,
  output logic [1:0]          m1_r_resp,
  output logic                m1_r_valid,
  input  logic                m1_r_ready,
  output logic [ADDR_LEN-1:0] s_ar_addr,
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  input  logic [DATA_LEN-1:0] s_r_data,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_valid,
  output logic                s_r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   pick;
  logic   in_addr, in_data;
  logic   sel_ar_valid, sel_r_ready;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick = (m0_ar_valid & m1_ar_valid) ? ~last_grant_q : m1_ar_valid;
`else
    pick = m1_ar_valid;
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_ar_valid | m1_ar_valid) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_ar_valid & s_ar_ready) state_d = DATA;
      end
      DATA: begin
        if (s_r_valid & s_r_ready) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Handshake signals are gated by rstn so an abandoned transaction never leaks out
  // during the reset cycle, before state_q has returned to IDLE.
  always_comb begin
    in_addr      = (state_q == ADDR);
    in_data      = (state_q == DATA);
    sel_ar_valid = grant_q ? m1_ar_valid : m0_ar_valid;
    sel_r_ready  = grant_q ? m1_r_ready : m0_r_ready;

    s_ar_valid   = rstn & in_addr & sel_ar_valid;
    s_ar_addr    = in_addr ? (grant_q ? m1_ar_addr : m0_ar_addr) : '0;
    s_r_ready    = rstn & in_data & sel_r_ready;

    m0_ar_ready  = rstn & in_addr & ~grant_q & s_ar_ready;
    m1_ar_ready  = rstn & in_addr &  grant_q & s_ar_ready;

    m0_r_valid   = rstn & in_data & ~grant_q & s_r_valid;
    m1_r_valid   = rstn & in_data &  grant_q & s_r_valid;
    m0_r_data    = (in_data & ~grant_q) ? s_r_data : '0;
    m1_r_data    = (in_data &  grant_q) ? s_r_data : '0;
    m0_r_resp    = (in_data & ~grant_q) ? s_r_resp : 2'b00;
    m1_r_resp    = (in_data &  grant_q) ? s_r_resp : 2'b00;
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Self-checking bench for ysyx_23060025_rd_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of ownership, handshakes and priority.
module tb_ysyx_23060025_rd_arbiter;

  logic        clock;
  logic        rstn;
  logic [31:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
  logic        m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [31:0] m0_r_data, m1_r_data, s_r_data;
  logic [1:0]  m0_r_resp, m1_r_resp, s_r_resp;
  logic        m0_r_valid, m0_r_ready, m1_r_valid, m1_r_ready;
  logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;

  int checks = 0;
  int errors = 0;

  ysyx_23060025_rd_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clock(clock), .rstn(rstn),
    .m0_ar_addr(m0_ar_addr), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m1_ar_addr(m1_ar_addr), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m0_ar_addr = '0; m0_ar_valid = 1'b0; m0_r_ready = 1'b0;
    m1_ar_addr = '0; m1_ar_valid = 1'b0; m1_r_ready = 1'b0;
    s_ar_ready = 1'b0; s_r_data = '0; s_r_resp = 2'b00; s_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    rstn = 1'b0;
    clear_inputs();
    m0_ar_valid = 1'b1; m1_ar_valid = 1'b1; s_ar_ready = 1'b1; s_r_valid = 1'b1;
    m0_r_ready = 1'b1; m1_r_ready = 1'b1; s_r_data = 32'hdead_beef; s_r_resp = 2'b11;
    repeat (2) @(negedge clock);
    #1;
    hs = {m0_ar_ready, m0_r_valid, m1_ar_ready, m1_r_valid, s_ar_valid, s_r_ready};
    checks++;
    if (hs !== 6'b0) begin
      errors++; $display("FAIL reset_gating: got %b expected 000000", hs);
    end
    @(negedge clock);
    clear_inputs();
    s_r_data = 32'h5a5a_5a5a; s_r_resp = 2'b10; s_r_valid = 1'b1;
    rstn = 1'b1;
    #1;
    checks++;
    if ({m0_r_data, m0_r_resp, m1_r_data, m1_r_resp, m0_r_valid, m1_r_valid, s_ar_valid, s_r_ready} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got m0_r_data=%h m0_r_resp=%b m1_r_data=%h m1_r_resp=%b, expected all 0",
               m0_r_data, m0_r_resp, m1_r_data, m1_r_resp);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_m0_only();
    @(negedge clock);
    m0_ar_addr = 32'ha000_0048; m0_ar_valid = 1'b1; s_ar_ready = 1'b1; m0_r_ready = 1'b1;
    #1;
    checks++;
    if ({s_ar_valid, m0_ar_ready} !== 2'b00) begin
      errors++; $display("FAIL arb_latency: got s_ar_valid,m0_ar_ready=%b expected 00", {s_ar_valid, m0_ar_ready});
    end
    @(negedge clock);
    #1;
    checks++;
    if ({s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready} !== {1'b1, 32'ha000_0048, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL m0_addr_phase: got valid=%b addr=%h m0_rdy=%b m1_rdy=%b expected 1 a0000048 1 0",
               s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready);
    end
    @(negedge clock);
    m0_ar_valid = 1'b0; s_ar_ready = 1'b0;
    #1;
    checks++;
    if ({s_ar_valid, m0_r_valid, s_r_ready} !== 3'b001) begin
      errors++; $display("FAIL m0_data_wait: got %b expected 001", {s_ar_valid, m0_r_valid, s_r_ready});
    end
    @(negedge clock);
    @(negedge clock);
    s_r_valid = 1'b1; s_r_data = 32'h0000_1234; s_r_resp = 2'b00;
    #1;
    checks++;
    if ({m0_r_valid, m0_r_data, m0_r_resp, m1_r_valid, s_r_ready} !== {1'b1, 32'h1234, 2'b00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL m0_data: got valid=%b data=%h resp=%b m1_valid=%b s_r_ready=%b expected 1 00001234 00 0 1",
               m0_r_valid, m0_r_data, m0_r_resp, m1_r_valid, s_r_ready);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({m0_r_valid, s_r_ready} !== 2'b00) begin
      errors++; $display("FAIL m0_return_idle: got %b expected 00", {m0_r_valid, s_r_ready});
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    @(negedge clock);
    m0_ar_addr = 32'h1000_0000; m1_ar_addr = 32'h2000_0004;
    m0_ar_valid = 1'b1; m1_ar_valid = 1'b1; m0_r_ready = 1'b1; m1_r_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if ({s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready} !== {1'b1, 32'h2000_0004, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_m1_first: got valid=%b addr=%h m0_rdy=%b m1_rdy=%b expected 1 20000004 0 0",
               s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready);
    end
    s_ar_ready = 1'b1;
    #1;
    checks++;
    if ({m0_ar_ready, m1_ar_ready} !== 2'b01) begin
      errors++; $display("FAIL prio_ready: got m0,m1 ar_ready=%b expected 01", {m0_ar_ready, m1_ar_ready});
    end
    @(negedge clock);
    m1_ar_valid = 1'b0; s_ar_ready = 1'b0; s_r_valid = 1'b1; s_r_data = 32'hcafe_0001;
    #1;
    checks++;
    if ({m1_r_valid, m1_r_data, m0_r_valid, m0_ar_ready} !== {1'b1, 32'hcafe_0001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_m1_data: got m1_valid=%b data=%h m0_valid=%b m0_ar_ready=%b expected 1 cafe0001 0 0",
               m1_r_valid, m1_r_data, m0_r_valid, m0_ar_ready);
    end
    @(negedge clock);
    s_r_valid = 1'b0;
    @(negedge clock);
    s_ar_ready = 1'b1;
    #1;
    checks++;
    if ({s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready} !== {1'b1, 32'h1000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL prio_m0_next: got valid=%b addr=%h m0_rdy=%b m1_rdy=%b expected 1 10000000 1 0",
               s_ar_valid, s_ar_addr, m0_ar_ready, m1_ar_ready);
    end
    @(negedge clock);
    m0_ar_valid = 1'b0; s_ar_ready = 1'b0; s_r_valid = 1'b1; s_r_data = 32'hcafe_0002;
    #1;
    checks++;
    if ({m0_r_valid, m0_r_data, m1_r_valid} !== {1'b1, 32'hcafe_0002, 1'b0}) begin
      errors++;
      $display("FAIL prio_m0_data: got m0_valid=%b data=%h m1_valid=%b expected 1 cafe0002 0",
               m0_r_valid, m0_r_data, m1_r_valid);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_grant_order();
    int         n;
    logic       prev;
    logic [1:0] got, exp;
    n = 0; prev = 1'b0;
    @(negedge clock);
    m0_ar_addr = 32'h0000_1000; m1_ar_addr = 32'h0000_2000;
    m0_ar_valid = 1'b1; m1_ar_valid = 1'b1; s_ar_ready = 1'b1; s_r_valid = 1'b1;
    m0_r_ready = 1'b1; m1_r_ready = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (s_ar_valid) begin
        got = {m1_ar_ready, m0_ar_ready};
`ifdef ARB_ROUND_ROBIN_EN
        exp = prev ? 2'b01 : 2'b10;
`else
        exp = 2'b10;
`endif
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL grant_order[%0d]: got m1,m0 ready=%b expected %b", n, got, exp);
        end
        prev = (exp == 2'b10);
        n++;
      end
      @(negedge clock);
      if (n == 4) begin
        m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL grant_order_timeout: got %0d grants expected 4", n);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    m1_ar_addr = 32'h3000_0010; m1_ar_valid = 1'b1; s_ar_ready = 1'b1; m1_r_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    m1_ar_valid = 1'b0; s_ar_ready = 1'b0;
    s_r_valid = 1'b1; s_r_data = 32'h7777_aaaa; s_r_resp = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({s_r_ready, m1_r_valid, m1_r_data, m1_r_resp, m0_r_valid} !== {1'b0, 1'b1, 32'h7777_aaaa, 2'b11, 1'b0}) begin
        errors++;
        $display("FAIL backpressure[%0d]: got s_r_ready=%b valid=%b data=%h resp=%b m0_valid=%b expected 0 1 7777aaaa 11 0",
                 i, s_r_ready, m1_r_valid, m1_r_data, m1_r_resp, m0_r_valid);
      end
      @(negedge clock);
    end
    m1_r_ready = 1'b1;
    #1;
    checks++;
    if ({s_r_ready, m1_r_valid, m1_r_resp} !== 4'b1111) begin
      errors++; $display("FAIL backpressure_release: got %b expected 1111", {s_r_ready, m1_r_valid, m1_r_resp});
    end
    @(negedge clock);
    #1;
    checks++;
    if ({s_r_ready, m1_r_valid, m1_r_resp} !== 4'b0000) begin
      errors++; $display("FAIL backpressure_idle: got %b expected 0000", {s_r_ready, m1_r_valid, m1_r_resp});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_data();
    @(negedge clock);
    m0_ar_addr = 32'h4000_0000; m0_ar_valid = 1'b1; s_ar_ready = 1'b1; m0_r_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    m0_ar_valid = 1'b0; s_ar_ready = 1'b0;
    #1;
    checks++;
    if (s_r_ready !== 1'b1) begin
      errors++; $display("FAIL rst_pre_data: got s_r_ready=%b expected 1", s_r_ready);
    end
    rstn = 1'b0; s_r_valid = 1'b1; s_r_data = 32'hbad0_bad0;
    m1_ar_addr = 32'h5000_0008; m1_ar_valid = 1'b1; m1_r_ready = 1'b1; s_ar_ready = 1'b1;
    #1;
    checks++;
    if ({m0_ar_ready, m0_r_valid, m1_ar_ready, m1_r_valid, s_ar_valid, s_r_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_gating: got %b expected 000000",
               {m0_ar_ready, m0_r_valid, m1_ar_ready, m1_r_valid, s_ar_valid, s_r_ready});
    end
    @(negedge clock);
    rstn = 1'b1;
    #1;
    checks++;
    if ({m0_r_valid, s_r_ready, s_ar_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_idle: got %b expected 000", {m0_r_valid, s_r_ready, s_ar_valid});
    end
    @(negedge clock);
    #1;
    checks++;
    if ({s_ar_valid, s_ar_addr, m1_ar_ready, m0_ar_ready} !== {1'b1, 32'h5000_0008, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_rearbitrate: got valid=%b addr=%h m1_rdy=%b m0_rdy=%b expected 1 50000008 1 0",
               s_ar_valid, s_ar_addr, m1_ar_ready, m0_ar_ready);
    end
    @(negedge clock);
    m1_ar_valid = 1'b0; s_ar_ready = 1'b0; s_r_data = 32'h600d_600d;
    #1;
    checks++;
    if ({m1_r_valid, m1_r_data, m0_r_valid} !== {1'b1, 32'h600d_600d, 1'b0}) begin
      errors++;
      $display("FAIL rst_after_data: got m1_valid=%b data=%h m0_valid=%b expected 1 600d600d 0",
               m1_r_valid, m1_r_data, m0_r_valid);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  // Reference model: tracks which master owns the slave and whether its address has been
  // accepted; expectations follow from the routing and priority rules of the arbiter.
  task automatic test_random();
    int          owner;
    bit          addr_done, last, req0, req1;
    logic [31:0] a0, a1;
    logic        own_ar_valid, own_r_ready;
    logic [73:0] exp_v, got_v;
    logic        e_ar0, e_ar1, e_rv0, e_rv1, e_sarv, e_srr;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_rs0, e_rs1;
    @(negedge clock);
    clear_inputs();
    rstn = 1'b0;
    @(negedge clock);
    rstn = 1'b1;
    owner = -1; addr_done = 1'b0; last = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!req0 && ($urandom % 3 == 0)) begin req0 = 1'b1; a0 = $urandom; end
      if (!req1 && ($urandom % 3 == 0)) begin req1 = 1'b1; a1 = $urandom; end
      m0_ar_addr  = a0; m1_ar_addr = a1;
      m0_ar_valid = req0 && ($urandom % 4 != 0);
      m1_ar_valid = req1 && ($urandom % 4 != 0);
      m0_r_ready  = ($urandom % 4 != 0);
      m1_r_ready  = ($urandom % 4 != 0);
      s_ar_ready  = $urandom % 2;
      s_r_valid   = $urandom % 2;
      s_r_data    = $urandom;
      s_r_resp    = 2'($urandom % 4);
      #1;
      own_ar_valid = (owner == 1) ? m1_ar_valid : m0_ar_valid;
      own_r_ready  = (owner == 1) ? m1_r_ready : m0_r_ready;
      e_ar0 = 0; e_ar1 = 0; e_rv0 = 0; e_rv1 = 0; e_sarv = 0; e_srr = 0;
      e_d0 = '0; e_d1 = '0; e_rs0 = 2'b00; e_rs1 = 2'b00;
      if (owner >= 0 && !addr_done) begin
        e_sarv = own_ar_valid;
        if (owner == 1) e_ar1 = s_ar_ready; else e_ar0 = s_ar_ready;
        checks++;
        if (s_ar_addr !== ((owner == 1) ? a1 : a0)) begin
          errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", c, s_ar_addr, (owner == 1) ? a1 : a0);
        end
      end else if (owner >= 0) begin
        e_srr = own_r_ready;
        if (owner == 1) begin e_rv1 = s_r_valid; e_d1 = s_r_data; e_rs1 = s_r_resp; end
        else begin e_rv0 = s_r_valid; e_d0 = s_r_data; e_rs0 = s_r_resp; end
      end
      exp_v = {e_ar0, e_rv0, e_d0, e_rs0, e_ar1, e_rv1, e_d1, e_rs1, e_sarv, e_srr};
      got_v = {m0_ar_ready, m0_r_valid, m0_r_data, m0_r_resp, m1_ar_ready, m1_r_valid, m1_r_data, m1_r_resp,
               s_ar_valid, s_r_ready};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL rand_outputs[%0d]: got %h expected %h (owner %0d)", c, got_v, exp_v, owner);
      end
      if (owner < 0) begin
        if (m0_ar_valid || m1_ar_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = (m0_ar_valid && m1_ar_valid) ? int'(!last) : int'(m1_ar_valid);
`else
          owner = int'(m1_ar_valid);
`endif
          addr_done = 1'b0;
        end
      end else if (!addr_done) begin
        if (own_ar_valid && s_ar_ready) begin
          addr_done = 1'b1;
          if (owner == 1) req1 = 1'b0; else req0 = 1'b0;
        end
      end else if (s_r_valid && own_r_ready) begin
        last  = (owner == 1);
        owner = -1;
      end
    end
    @(negedge clock);
    clear_inputs();
    rstn = 1'b0;
    @(negedge clock);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_m0_only();
    test_priority();
    test_grant_order();
    test_backpressure();
    test_random();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
